// File: rtl/tile_arb_pkg.sv
// -----------------------------------------------------------------------------
// tile_arb_pkg
// Shared types and constants for the tile ROM arbiter.
//   arb_state_t  : arbiter states (IDLE / ISSUE / RETURN)
//   TILE_W/H     : tile geometry in pixels
//   DEF_ADDR_W   : default ROM address width (one 32x32 tile)
//   DEF_PIX_W    : default palette index width
// -----------------------------------------------------------------------------
package tile_arb_pkg;

  localparam int TILE_W     = 32;
  localparam int TILE_H     = 32;
  localparam int DEF_ADDR_W = $clog2(TILE_W * TILE_H);
  localparam int DEF_PIX_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RETURN
  } arb_state_t;

endpackage

// File: rtl/tile_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tile_rom_arbiter
// Shares one synchronous single-port tile ROM between the display path and a
// game-logic requester. The display owns the ROM during the visible region
// (blank high); a pending game request is served at once during blanking, or
// steals one display cycle after waiting MAX_WAIT visible cycles.
//
// Ports:
//   vga_clk      clock, everything updates on posedge
//   reset        synchronous, active-high
//   blank        1 = visible region, 0 = blanking
//   disp_addr    display ROM address (new every cycle)
//   disp_q       palette index for disp_addr two cycles earlier
//   disp_hold    disp_q is a repeat caused by a stolen cycle
//   gl_req       game request (level, held until gl_ack)
//   gl_addr      game address, stable while gl_req high
//   gl_ack       one-cycle pulse, gl_addr is on the ROM this cycle
//   gl_valid     one-cycle pulse, gl_q holds the game word
//   gl_q         ROM word for the accepted gl_addr
//   rom_address  ROM address (combinational mux)
//   rom_q        ROM data, valid one cycle after the address
// -----------------------------------------------------------------------------
module tile_rom_arbiter
  import tile_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int PIX_W    = DEF_PIX_W,
  parameter int MAX_WAIT = 64
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              blank,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [PIX_W-1:0]  disp_q,
  output logic              disp_hold,
  input  logic              gl_req,
  input  logic [ADDR_W-1:0] gl_addr,
  output logic              gl_ack,
  output logic              gl_valid,
  output logic [PIX_W-1:0]  gl_q,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [PIX_W-1:0]  rom_q
);

  localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  arb_state_t        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        steal_tag;  // [0]: rom_q holds a stolen word, [1]: disp_q repeated
  logic              grant;

  // Accept in IDLE: immediately during blanking, or once the wait budget is spent.
  assign grant = (state == IDLE) && gl_req && (!blank || (wait_cnt == WAIT_LAST));

  // The game address owns the ROM only for the single ISSUE cycle.
  assign rom_address = (state == ISSUE) ? gl_addr : disp_addr;

  // The second tag stage is itself a flop, so disp_hold stays registered.
  assign disp_hold = steal_tag[1];

  // NOTE: all state here uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, regardless of statement order.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      steal_tag <= '0;
      disp_q    <= '0;
      gl_ack    <= 1'b0;
      gl_valid  <= 1'b0;
      gl_q      <= '0;
    end else begin
      unique case (state)
        IDLE:    if (grant) state <= ISSUE;
        ISSUE:   state <= RETURN;
        RETURN:  state <= IDLE;
        default: state <= IDLE;
      endcase

      gl_ack   <= grant;
      gl_valid <= (state == RETURN);
      if (state == RETURN) gl_q <= rom_q;

      // Waiting accrues only while visible; blanking freezes it, a withdrawn
      // or granted request starts the budget over.
      if (!gl_req || grant) begin
        wait_cnt <= '0;
      end else if ((state == IDLE) && blank && (wait_cnt != WAIT_LAST)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      // Only a visible-region ISSUE costs the display a pixel.
      steal_tag <= {steal_tag[0], (state == ISSUE) && blank};

      // rom_q carries the game word in the stolen slot; repeat the last pixel.
      if (!steal_tag[0]) disp_q <= rom_q;
    end
  end

endmodule

// File: tb/tb_tile_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tile_rom_arbiter
// Directed bench for tile_rom_arbiter with MAX_WAIT=4 and a ROM whose word is
// addr[3:0]. disp_addr follows the cycle number, so an unstolen disp_q equals
// (cycle-2)[3:0]. Cycle n is the period after the n-th rising edge counted from
// the first cycle with reset low.
// -----------------------------------------------------------------------------
module tb_tile_rom_arbiter;

  localparam int ADDR_W = 10;
  localparam int PIX_W  = 4;

  logic              vga_clk;
  logic              reset;
  logic              blank;
  logic [ADDR_W-1:0] disp_addr;
  logic [PIX_W-1:0]  disp_q;
  logic              disp_hold;
  logic              gl_req;
  logic [ADDR_W-1:0] gl_addr;
  logic              gl_ack;
  logic              gl_valid;
  logic [PIX_W-1:0]  gl_q;
  logic [ADDR_W-1:0] rom_address;
  logic [PIX_W-1:0]  rom_q;

  int vectors;
  int miscompares;
  int cyc;

  tile_rom_arbiter #(
    .ADDR_W  (ADDR_W),
    .PIX_W   (PIX_W),
    .MAX_WAIT(4)
  ) dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .blank      (blank),
    .disp_addr  (disp_addr),
    .disp_q     (disp_q),
    .disp_hold  (disp_hold),
    .gl_req     (gl_req),
    .gl_addr    (gl_addr),
    .gl_ack     (gl_ack),
    .gl_valid   (gl_valid),
    .gl_q       (gl_q),
    .rom_address(rom_address),
    .rom_q      (rom_q)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // Synchronous ROM: word = low nibble of the address.
  always_ff @(posedge vga_clk) rom_q <= rom_address[3:0];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one cycle, apply the inputs for it, and let combinational logic settle.
  task automatic cycle_in(input logic b, input logic req, input logic [ADDR_W-1:0] ga,
                          input logic rst);
    @(posedge vga_clk);
    #1;
    cyc++;
    disp_addr = (cyc < 0) ? '0 : ADDR_W'(cyc);
    blank     = b;
    gl_req    = req;
    gl_addr   = ga;
    reset     = rst;
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = -4;
    reset       = 1'b1;
    blank       = 1'b1;
    gl_req      = 1'b0;
    gl_addr     = 10'h3FF;
    disp_addr   = '0;

    // Reset: every registered output cleared.
    repeat (3) cycle_in(1'b1, 1'b0, 10'h3FF, 1'b1);
    check("rst_disp_q",    16'(disp_q),    16'h0);
    check("rst_disp_hold", 16'(disp_hold), 16'h0);
    check("rst_gl_ack",    16'(gl_ack),    16'h0);
    check("rst_gl_valid",  16'(gl_valid),  16'h0);
    check("rst_gl_q",      16'(gl_q),      16'h0);

    // Cycles 0..7: display ramp, disp_q = 0,0,0,1,2,... two cycles behind.
    for (int k = 0; k < 8; k++) begin
      cycle_in(1'b1, 1'b0, 10'h3FF, 1'b0);
      check("ramp_disp_q",    16'(disp_q),      (cyc < 2) ? 16'h0 : 16'((cyc - 2) % 16));
      check("ramp_disp_hold", 16'(disp_hold),   16'h0);
      check("ramp_rom_addr",  16'(rom_address), 16'(cyc));
    end

    // Blanking request at cycle 10: ack 11, valid 13 with word 5.
    repeat (2) cycle_in(1'b1, 1'b0, 10'h155, 1'b0);         // 8, 9
    cycle_in(1'b0, 1'b1, 10'h155, 1'b0);                    // 10
    cycle_in(1'b0, 1'b1, 10'h155, 1'b0);                    // 11
    check("blank_ack",      16'(gl_ack),      16'h1);
    check("blank_rom_addr", 16'(rom_address), 16'h155);
    cycle_in(1'b0, 1'b0, 10'h155, 1'b0);                    // 12
    check("blank_ack_pulse", 16'(gl_ack),      16'h0);
    check("blank_early_vld", 16'(gl_valid),    16'h0);
    check("blank_ret_addr",  16'(rom_address), 16'd12);
    cycle_in(1'b0, 1'b0, 10'h155, 1'b0);                    // 13
    check("blank_valid",  16'(gl_valid),  16'h1);
    check("blank_gl_q",   16'(gl_q),      16'h5);
    check("blank_disp_q", 16'(disp_q),    16'h5);
    check("blank_hold",   16'(disp_hold), 16'h0);
    cycle_in(1'b0, 1'b0, 10'h155, 1'b0);                    // 14
    check("blank_valid_pulse", 16'(gl_valid), 16'h0);

    // Visible request from cycle 20: ack 24, stolen slot shows at 26.
    repeat (5) cycle_in(1'b1, 1'b0, 10'h3AE, 1'b0);         // 15..19
    for (int k = 0; k < 4; k++) begin                       // 20..23
      cycle_in(1'b1, 1'b1, 10'h3AE, 1'b0);
      check("steal_wait_ack", 16'(gl_ack), 16'h0);
    end
    cycle_in(1'b1, 1'b1, 10'h3AE, 1'b0);                    // 24
    check("steal_ack",      16'(gl_ack),      16'h1);
    check("steal_rom_addr", 16'(rom_address), 16'h3AE);
    cycle_in(1'b1, 1'b0, 10'h3AE, 1'b0);                    // 25
    check("steal_pre_q",    16'(disp_q),    16'h7);
    check("steal_pre_hold", 16'(disp_hold), 16'h0);
    cycle_in(1'b1, 1'b0, 10'h3AE, 1'b0);                    // 26
    check("steal_rep_q",  16'(disp_q),    16'h7);
    check("steal_hold",   16'(disp_hold), 16'h1);
    check("steal_valid",  16'(gl_valid),  16'h1);
    check("steal_gl_q",   16'(gl_q),      16'hE);
    check("steal_no_ack", 16'(gl_ack),    16'h0);
    cycle_in(1'b1, 1'b0, 10'h3AE, 1'b0);                    // 27
    check("steal_post_q",    16'(disp_q),    16'h9);
    check("steal_post_hold", 16'(disp_hold), 16'h0);

    // Two-cycle request withdrawn at 32, then held from 34: full wait, ack at 38.
    repeat (2) cycle_in(1'b1, 1'b0, 10'h001, 1'b0);         // 28, 29
    cycle_in(1'b1, 1'b1, 10'h001, 1'b0);                    // 30
    cycle_in(1'b1, 1'b1, 10'h001, 1'b0);                    // 31
    check("drop_no_ack", 16'(gl_ack), 16'h0);
    for (int k = 0; k < 2; k++) begin                       // 32, 33
      cycle_in(1'b1, 1'b0, 10'h001, 1'b0);
      check("drop_no_ack", 16'(gl_ack), 16'h0);
    end
    for (int k = 0; k < 4; k++) begin                       // 34..37
      cycle_in(1'b1, 1'b1, 10'h001, 1'b0);
      check("rewait_no_ack", 16'(gl_ack), 16'h0);
    end
    cycle_in(1'b1, 1'b1, 10'h001, 1'b0);                    // 38
    check("rewait_ack", 16'(gl_ack), 16'h1);
    cycle_in(1'b1, 1'b0, 10'h001, 1'b0);                    // 39
    cycle_in(1'b1, 1'b0, 10'h001, 1'b0);                    // 40
    check("rewait_valid",  16'(gl_valid),  16'h1);
    check("rewait_gl_q",   16'(gl_q),      16'h1);
    check("rewait_hold",   16'(disp_hold), 16'h1);
    check("rewait_disp_q", 16'(disp_q),    16'h5);

    // Continuous blanking request from 45: ack every third cycle, valid two later.
    repeat (4) cycle_in(1'b0, 1'b0, 10'h0AC, 1'b0);         // 41..44
    cycle_in(1'b0, 1'b1, 10'h0AC, 1'b0);                    // 45
    for (int k = 1; k <= 9; k++) begin                      // 46..54
      cycle_in(1'b0, 1'b1, 10'h0AC, 1'b0);
      check("burst_ack",   16'(gl_ack),    (k % 3 == 1) ? 16'h1 : 16'h0);
      check("burst_valid", 16'(gl_valid),  (k % 3 == 0) ? 16'h1 : 16'h0);
      check("burst_excl",  16'(gl_ack & gl_valid), 16'h0);
      check("burst_hold",  16'(disp_hold), 16'h0);
      if (gl_valid) check("burst_gl_q", 16'(gl_q), 16'hC);
    end

    // Reset the cycle after an ack: transaction discarded, outputs cleared.
    repeat (5) cycle_in(1'b0, 1'b0, 10'h155, 1'b0);         // 55..59
    cycle_in(1'b0, 1'b1, 10'h155, 1'b0);                    // 60
    cycle_in(1'b0, 1'b1, 10'h155, 1'b0);                    // 61
    check("abort_ack", 16'(gl_ack), 16'h1);
    cycle_in(1'b0, 1'b0, 10'h155, 1'b1);                    // 62
    cycle_in(1'b0, 1'b0, 10'h155, 1'b0);                    // 63
    check("abort_gl_ack",    16'(gl_ack),      16'h0);
    check("abort_gl_valid",  16'(gl_valid),    16'h0);
    check("abort_gl_q",      16'(gl_q),        16'h0);
    check("abort_disp_q",    16'(disp_q),      16'h0);
    check("abort_disp_hold", 16'(disp_hold),   16'h0);
    check("abort_rom_addr",  16'(rom_address), 16'd63);
    cycle_in(1'b0, 1'b0, 10'h155, 1'b0);                    // 64
    check("abort_no_valid", 16'(gl_valid), 16'h0);
    check("abort_no_ack",   16'(gl_ack),   16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
